// File: rtl/wbm_host_seq_if.sv
// Host request/response channel and Wishbone initiator signals of wbm_host_seq.
// The master modport is the sequencer side; slave is the command source plus bus slave.
interface wbm_host_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_single;
  logic [31:0] req_base;
  logic [15:0] req_index;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  req_valid, req_we, req_single, req_base, req_index, req_wdata, rsp_ready,
    input  wbm_dat_i, wbm_ack_i,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output req_valid, req_we, req_single, req_base, req_index, req_wdata, rsp_ready,
    output wbm_dat_i, wbm_ack_i,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wbm_host_seq.sv
// Wishbone initiator: splits 64-bit host word requests into one or two 32-bit beats
// with a one-cycle strobe gap between beats and a per-beat ack timeout.
module wbm_host_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wbm_host_seq_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_GAP, S_HI, S_RESP} state_t;

  state_t        r_state, w_state;
  logic          r_cyc, w_cyc;
  logic          r_stb, w_stb;
  logic          r_we, w_we;
  logic [3:0]    r_sel, w_sel;
  logic [31:0]   r_adr, w_adr;
  logic [31:0]   r_dat, w_dat;
  logic [31:0]   r_wdata_hi, w_wdata_hi;
  logic          r_single, w_single;
  logic [63:0]   r_rdata, w_rdata;
  logic          r_err, w_err;
  logic [CW-1:0] r_cnt, w_cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_wdata_hi <= '0;
      r_single   <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state;
      r_cyc      <= w_cyc;
      r_stb      <= w_stb;
      r_we       <= w_we;
      r_sel      <= w_sel;
      r_adr      <= w_adr;
      r_dat      <= w_dat;
      r_wdata_hi <= w_wdata_hi;
      r_single   <= w_single;
      r_rdata    <= w_rdata;
      r_err      <= w_err;
      r_cnt      <= w_cnt;
    end
  end

  // Next values of every bus output are computed here so the outputs themselves stay registered.
  always_comb begin
    w_state    = r_state;
    w_cyc      = r_cyc;
    w_stb      = r_stb;
    w_we       = r_we;
    w_sel      = r_sel;
    w_adr      = r_adr;
    w_dat      = r_dat;
    w_wdata_hi = r_wdata_hi;
    w_single   = r_single;
    w_rdata    = r_rdata;
    w_err      = r_err;
    w_cnt      = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_state    = S_LO;
          w_cyc      = 1'b1;
          w_stb      = 1'b1;
          w_sel      = '1;
          w_we       = bus.req_we;
          w_single   = bus.req_single;
          w_adr      = bus.req_single ? bus.req_base + {14'b0, bus.req_index, 2'b0}
                                      : bus.req_base + {13'b0, bus.req_index, 3'b0};
          w_dat      = bus.req_wdata[31:0];
          w_wdata_hi = bus.req_wdata[63:32];
          w_rdata    = '0;
          w_err      = 1'b0;
          w_cnt      = '0;
        end
      end

      S_LO, S_HI: begin
        // An ack on the final wait edge wins over the timeout.
        if (bus.wbm_ack_i) begin
          if (!r_we) begin
            if (r_state == S_LO) w_rdata[31:0]  = bus.wbm_dat_i;
            else                 w_rdata[63:32] = bus.wbm_dat_i;
          end
          w_stb = 1'b0;
          w_sel = '0;
          if (r_state == S_LO && !r_single) begin
            w_state = S_GAP;
          end else begin
            w_state = S_RESP;
            w_cyc   = 1'b0;
          end
        end else if (r_cnt == LAST_WAIT) begin
          w_state = S_RESP;
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_sel   = '0;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      S_GAP: begin
        w_state = S_HI;
        w_stb   = 1'b1;
        w_sel   = '1;
        w_adr   = r_adr + 32'd4;
        w_dat   = r_wdata_hi;
        w_cnt   = '0;
      end

      S_RESP: begin
        if (bus.rsp_ready) w_state = S_IDLE;
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.wbm_cyc_o = r_cyc;
  assign bus.wbm_stb_o = r_stb;
  assign bus.wbm_we_o  = r_we;
  assign bus.wbm_sel_o = r_sel;
  assign bus.wbm_adr_o = r_adr;
  assign bus.wbm_dat_o = r_dat;

endmodule

// File: tb/tb_wbm_host_seq.sv
// Bench for wbm_host_seq: directed and random requests against a memory-level
// reference model, with a Wishbone slave whose per-beat wait can be set or disabled.
module tb_wbm_host_seq;
  localparam int unsigned TO = 8;
  localparam int DEAD = 255;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;

  wbm_host_seq_if bus();

  wbm_host_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  int ncmp = 0;
  int nfail = 0;

  beat_t       slog[$];
  logic [31:0] smem[logic [31:0]];
  logic [31:0] mdl[logic [31:0]];
  logic [31:0] pre[logic [31:0]];
  int          slv_wait[2];
  int          beat_no = 0;
  int          wcnt = 0;
  bit          stray = 1'b0;

  int          stb_cnt = 0;
  int          gap_cnt = 0;
  int          sel_bad = 0;
  int          unstable = 0;
  logic        prev_stb = 1'b0;
  logic [64:0] prev_bus = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] sread(input logic [31:0] a);
    if (smem.exists(a)) return smem[a];
    if (pre.exists(a))  return pre[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (mdl.exists(a)) return mdl[a];
    if (pre.exists(a)) return pre[a];
    return dflt(a);
  endfunction

  // Wishbone slave: acks after slv_wait[beat] strobe cycles, never if DEAD.
  always @(negedge wb_clk_i) begin
    if (stray) begin
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = $urandom;
    end else if (bus.wbm_ack_i === 1'b1 || !(bus.wbm_cyc_o === 1'b1 && bus.wbm_stb_o === 1'b1)) begin
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = '0;
      wcnt = 0;
      if (bus.wbm_cyc_o !== 1'b1) beat_no = 0;
    end else if (beat_no < 2 && slv_wait[beat_no] != DEAD && wcnt == slv_wait[beat_no]) begin
      bus.wbm_ack_i = 1'b1;
      if (bus.wbm_we_o) begin
        smem[bus.wbm_adr_o] = bus.wbm_dat_o;
        slog.push_back('{adr: bus.wbm_adr_o, we: 1'b1, dat: bus.wbm_dat_o});
      end else begin
        bus.wbm_dat_i = sread(bus.wbm_adr_o);
        slog.push_back('{adr: bus.wbm_adr_o, we: 1'b0, dat: bus.wbm_dat_i});
      end
      beat_no++;
      wcnt = 0;
    end else begin
      wcnt++;
    end
  end

  always @(negedge wb_clk_i) begin
    if (bus.wbm_stb_o === 1'b1) begin
      stb_cnt++;
      if (bus.wbm_sel_o !== 4'hF) sel_bad++;
      if (prev_stb && {bus.wbm_adr_o, bus.wbm_we_o, bus.wbm_dat_o} !== prev_bus) unstable++;
    end
    if (bus.wbm_cyc_o === 1'b1 && bus.wbm_stb_o === 1'b0) gap_cnt++;
    prev_stb = (bus.wbm_stb_o === 1'b1);
    prev_bus = {bus.wbm_adr_o, bus.wbm_we_o, bus.wbm_dat_o};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic single, input logic [31:0] base,
                         input logic [15:0] idx, input logic [63:0] wd,
                         input int wlo, input int whi, input int hold, input bit do_stray);
    logic [31:0] a0, a1, v0, v1;
    logic [63:0] exp_rd;
    logic        exp_err;
    beat_t       exp_q[$];
    int          exp_lat, exp_stb, exp_gap, n, l0, s0, g0, nb;

    a0 = single ? base + 32'(idx) * 32'd4 : base + 32'(idx) * 32'd8;
    a1 = a0 + 32'd4;
    v0 = we ? wd[31:0]  : mread(a0);
    v1 = we ? wd[63:32] : mread(a1);
    exp_rd  = '0;
    exp_err = 1'b0;
    if (wlo == DEAD) begin
      exp_err = 1'b1; exp_lat = int'(TO); exp_stb = int'(TO); exp_gap = 0;
    end else begin
      exp_q.push_back('{adr: a0, we: we, dat: v0});
      if (!we) exp_rd[31:0] = v0;
      if (single) begin
        exp_lat = wlo + 1; exp_stb = wlo + 1; exp_gap = 0;
      end else if (whi == DEAD) begin
        exp_err = 1'b1; exp_lat = wlo + 2 + int'(TO); exp_stb = wlo + 1 + int'(TO); exp_gap = 1;
      end else begin
        exp_q.push_back('{adr: a1, we: we, dat: v1});
        if (!we) exp_rd[63:32] = v1;
        exp_lat = wlo + whi + 3; exp_stb = wlo + whi + 2; exp_gap = 1;
      end
    end

    @(negedge wb_clk_i);
    slv_wait[0] = wlo;
    slv_wait[1] = whi;
    l0 = slog.size(); s0 = stb_cnt; g0 = gap_cnt;
    bus.req_we = we; bus.req_single = single; bus.req_base = base;
    bus.req_index = idx; bus.req_wdata = wd; bus.req_valid = 1'b1;
    chk("req_ready_idle", 64'(bus.req_ready), 64'(1));
    @(posedge wb_clk_i); #1;
    bus.req_valid = 1'b0;
    chk("accept_cyc_stb", 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'(2'b11));
    chk("accept_adr", 64'(bus.wbm_adr_o), 64'(a0));
    chk("accept_we", 64'(bus.wbm_we_o), 64'(we));
    if (we) chk("accept_dat", 64'(bus.wbm_dat_o), 64'(wd[31:0]));
    chk("err_cleared", 64'(bus.rsp_err), 64'(0));
    chk("ready_busy", 64'(bus.req_ready), 64'(0));

    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 200) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("resp_cyc_stb", 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'(0));

    for (int i = 0; i < hold; i++) begin
      if (do_stray) begin
        stray = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = ~we; bus.req_base = $urandom;
      end
      @(posedge wb_clk_i); #1;
      chk("hold_valid", 64'(bus.rsp_valid), 64'(1));
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_err", 64'(bus.rsp_err), 64'(exp_err));
      chk("hold_no_cyc", 64'(bus.wbm_cyc_o), 64'(0));
      chk("hold_ready", 64'(bus.req_ready), 64'(0));
    end

    @(negedge wb_clk_i);
    stray = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge wb_clk_i); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 64'(bus.rsp_valid), 64'(0));
    chk("ready_back", 64'(bus.req_ready), 64'(1));

    nb = slog.size() - l0;
    chk("beat_count", 64'(nb), 64'(exp_q.size()));
    for (int i = 0; i < nb && i < exp_q.size(); i++) begin
      chk("beat_adr", 64'(slog[l0 + i].adr), 64'(exp_q[i].adr));
      chk("beat_we",  64'(slog[l0 + i].we),  64'(exp_q[i].we));
      chk("beat_dat", 64'(slog[l0 + i].dat), 64'(exp_q[i].dat));
    end
    chk("stb_cycles", 64'(stb_cnt - s0), 64'(exp_stb));
    chk("gap_cycles", 64'(gap_cnt - g0), 64'(exp_gap));
    chk("sel_while_stb", 64'(sel_bad), 64'(0));
    chk("stable_while_stb", 64'(unstable), 64'(0));

    if (we) foreach (exp_q[i]) mdl[exp_q[i].adr] = exp_q[i].dat;
  endtask

  initial begin
    logic        r_we, r_single;
    logic [31:0] r_base;
    logic [15:0] r_idx;
    logic [63:0] r_wd;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_single = 1'b0;
    bus.req_base = '0; bus.req_index = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    slv_wait[0] = 0; slv_wait[1] = 0;
    pre[32'h3003_0038] = 32'hDEAD_BEEF;
    pre[32'h3003_003C] = 32'h1100_1010;

    #2;
    chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    chk("rst_cyc_stb_we", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}), 64'(0));
    chk("rst_sel", 64'(bus.wbm_sel_o), 64'(0));
    chk("rst_adr", 64'(bus.wbm_adr_o), 64'(0));
    chk("rst_dat", 64'(bus.wbm_dat_o), 64'(0));
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    run_txn(1'b1, 1'b0, 32'h3002_0000, 16'd3, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h3003_0000, 16'd7, 64'd0, 2, 2, 1, 1'b0);
    run_txn(1'b1, 1'b1, 32'h3000_0000, 16'd1, 64'd1, 0, 0, 0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h3001_0000, 16'd5, 64'd0, DEAD, 0, 0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h3001_0000, 16'd6, 64'd0, 1, DEAD, 2, 1'b0);
    run_txn(1'b0, 1'b1, 32'h3001_0000, 16'd9, 64'd0, int'(TO) - 1, 0, 0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h3002_0000, 16'd3, 64'd0, int'(TO) - 1, int'(TO) - 1, 0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h3003_0000, 16'd7, 64'd0, 0, 1, 5, 1'b1);
    run_txn(1'b1, 1'b0, 32'hFFFF_FFF8, 16'd0, 64'hAAAA_5555_0123_4567, 0, 0, 0, 1'b0);
    run_txn(1'b0, 1'b1, 32'hFFFF_FFFC, 16'd1, 64'd0, 1, 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, 32'h3000_0010, 16'hFFFF, 64'h0F0F_F0F0_1234_8765, 3, 0, 1, 1'b0);

    // Reset while the upper beat is waiting for its ack.
    @(negedge wb_clk_i);
    slv_wait[0] = 0; slv_wait[1] = 3;
    bus.req_we = 1'b1; bus.req_single = 1'b0; bus.req_base = 32'h3004_0000;
    bus.req_index = 16'd2; bus.req_wdata = 64'h1111_2222_3333_4444; bus.req_valid = 1'b1;
    @(posedge wb_clk_i); #1;
    bus.req_valid = 1'b0;
    @(posedge wb_clk_i);
    @(posedge wb_clk_i); #2;
    chk("hi_cyc_stb_pre_rst", 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'(2'b11));
    chk("hi_adr_pre_rst", 64'(bus.wbm_adr_o), 64'(32'h3004_0014));
    wb_rst_i = 1'b1;
    #1;
    chk("rst_mid_cyc_stb", 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'(0));
    chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_mid_req_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_mid_adr", 64'(bus.wbm_adr_o), 64'(0));
    chk("rst_mid_rdata", bus.rsp_rdata, 64'(0));
    mdl[32'h3004_0010] = 32'h3333_4444;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk_i); #1;
      chk("post_rst_quiet", 64'({bus.rsp_valid, bus.wbm_cyc_o}), 64'(0));
    end
    run_txn(1'b1, 1'b0, 32'h3004_0000, 16'd2, 64'h9999_8888_7777_6666, 1, 0, 0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h3004_0000, 16'd2, 64'd0, 0, 2, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      r_we     = 1'($urandom);
      r_single = 1'($urandom);
      r_idx    = 16'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: r_base = 32'h3000_0000;
        1: r_base = 32'h3001_0000;
        2: r_base = 32'h3002_0000;
        default: begin r_base = $urandom; r_idx = 16'($urandom); end
      endcase
      r_wd = {32'($urandom), 32'($urandom)};
      run_txn(r_we, r_single, r_base, r_idx, r_wd,
              int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
